// File: rtl/ibex_irq_arbiter.sv
// Interrupt arbiter: registers pending irqs, masks with mie/mstatus.MIE, presents the highest-priority cause over req/ack.
// Latency: input -> mip_o 1 edge, -> irq_req_o 2 edges (3/4 edges with IBEX_IRQ_SYNC_EN defined).
// Backpressure: a presented maskable cause is held until acked or withdrawn; only an eligible NMI may replace it.
module ibex_irq_arbiter #(
    parameter int unsigned NumFastIrq = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    irq_software_i,
    input  logic                    irq_timer_i,
    input  logic                    irq_external_i,
    input  logic [NumFastIrq-1:0]   irq_fast_i,
    input  logic                    irq_nm_i,
    input  logic [NumFastIrq+2:0]   mie_i,
    input  logic                    mstatus_mie_i,
    input  logic                    debug_mode_i,
    input  logic                    irq_ack_i,
    input  logic                    mret_i,
    output logic [NumFastIrq+2:0]   mip_o,
    output logic                    irq_req_o,
    output logic [5:0]              irq_cause_o,
    output logic                    irq_nm_o,
    output logic                    nmi_active_o
);

    localparam int unsigned NIRQ   = 3 + NumFastIrq;
    localparam int unsigned IDX_SW = NIRQ - 1;
    localparam int unsigned IDX_TM = NIRQ - 2;
    localparam int unsigned IDX_EX = NIRQ - 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_NMI_ACT = 2'd3
    } state_t;

    logic [NIRQ-1:0] w_lvl;
    logic            w_nm;

`ifdef IBEX_IRQ_SYNC_EN
    logic [NIRQ:0] r_sync1;
    logic [NIRQ:0] r_sync2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl = r_sync2[NIRQ-1:0];
    assign w_nm  = r_sync2[NIRQ];
`else
    assign w_lvl = {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
    assign w_nm  = irq_nm_i;
`endif

    logic [NIRQ-1:0] r_mip;
    logic            r_nm_q;
    logic            r_nmi_pending;
    logic            r_nmi_active;
    state_t          r_state;
    logic            r_req;
    logic [5:0]      r_cause;
    logic            r_nm;
    logic [NIRQ-1:0] r_sel;

    logic [NIRQ-1:0] w_enabled;
    logic            w_nmi_elig;
    logic            w_nm_edge;
    logic            w_win_vld;
    logic [5:0]      w_win_cause;
    logic            w_win_nm;
    logic [NIRQ-1:0] w_win_sel;

    assign w_enabled  = r_mip & mie_i & {NIRQ{mstatus_mie_i}};
    assign w_nmi_elig = r_nmi_pending & ~r_nmi_active;
    assign w_nm_edge  = w_nm & ~r_nm_q;

    // Lowest priority assigned first so later matches override.
    always_comb begin
        w_win_vld   = |w_enabled;
        w_win_cause = 6'h00;
        w_win_nm    = 1'b0;
        w_win_sel   = '0;
        if (w_enabled[IDX_TM]) begin
            w_win_cause = 6'h27;
            w_win_sel   = '0;
            w_win_sel[IDX_TM] = 1'b1;
        end
        if (w_enabled[IDX_SW]) begin
            w_win_cause = 6'h23;
            w_win_sel   = '0;
            w_win_sel[IDX_SW] = 1'b1;
        end
        if (w_enabled[IDX_EX]) begin
            w_win_cause = 6'h2B;
            w_win_sel   = '0;
            w_win_sel[IDX_EX] = 1'b1;
        end
        for (int i = int'(NumFastIrq) - 1; i >= 0; i--) begin
            if (w_enabled[i]) begin
                w_win_cause = 6'h30 + 6'(i);
                w_win_sel   = '0;
                w_win_sel[i] = 1'b1;
            end
        end
        if (w_nmi_elig) begin
            w_win_vld   = 1'b1;
            w_win_cause = 6'h3F;
            w_win_nm    = 1'b1;
            w_win_sel   = '0;
        end
    end

    state_t          w_state_n;
    logic            w_req_n;
    logic [5:0]      w_cause_n;
    logic            w_nm_n;
    logic [NIRQ-1:0] w_sel_n;
    logic            w_set_active;
    logic            w_can_req;

    assign w_can_req = w_win_vld & ~debug_mode_i;

    always_comb begin
        w_state_n    = r_state;
        w_req_n      = r_req;
        w_cause_n    = r_cause;
        w_nm_n       = r_nm;
        w_sel_n      = r_sel;
        w_set_active = 1'b0;
        case (r_state)
            S_REQ: begin
                if (irq_ack_i) begin
                    w_req_n = 1'b0;
                    if (r_nm) begin
                        w_set_active = 1'b1;
                        w_state_n    = S_NMI_ACT;
                    end else begin
                        w_state_n    = S_HOLD;
                    end
                end else if (debug_mode_i) begin
                    w_req_n   = 1'b0;
                    w_state_n = S_IDLE;
                end else if (w_nmi_elig && !r_nm) begin
                    w_cause_n = 6'h3F;
                    w_nm_n    = 1'b1;
                    w_sel_n   = '0;
                end else if (!r_nm && !(|(r_sel & w_enabled))) begin
                    w_req_n   = 1'b0;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                // IDLE, HOLD and NMI_ACT all arbitrate; HOLD has already spent its one low cycle.
                w_req_n = 1'b0;
                if (w_can_req) begin
                    w_state_n = S_REQ;
                    w_req_n   = 1'b1;
                    w_cause_n = w_win_cause;
                    w_nm_n    = w_win_nm;
                    w_sel_n   = w_win_sel;
                end else if (r_state == S_NMI_ACT && r_nmi_active) begin
                    w_state_n = S_NMI_ACT;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mip         <= '0;
            r_nm_q        <= 1'b0;
            r_nmi_pending <= 1'b0;
            r_nmi_active  <= 1'b0;
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_cause       <= 6'h00;
            r_nm          <= 1'b0;
            r_sel         <= '0;
        end else begin
            r_mip         <= w_lvl;
            r_nm_q        <= w_nm;
            // A new edge coinciding with the NMI ack must survive.
            r_nmi_pending <= w_nm_edge | (r_nmi_pending & ~(irq_ack_i & r_req & r_nm));
            if (w_set_active) begin
                r_nmi_active <= 1'b1;
            end else if (mret_i) begin
                r_nmi_active <= 1'b0;
            end
            r_state       <= w_state_n;
            r_req         <= w_req_n;
            r_cause       <= w_cause_n;
            r_nm          <= w_nm_n;
            r_sel         <= w_sel_n;
        end
    end

    assign mip_o        = r_mip;
    assign irq_req_o    = r_req;
    assign irq_cause_o  = r_cause;
    assign irq_nm_o     = r_nm;
    assign nmi_active_o = r_nmi_active;

    ack_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni) irq_ack_i |-> irq_req_o);

endmodule
